// File: rtl/coin_collector_if.sv
// Charge request channel between the coin collector and the cash handler.
// Latency: none, wires only.
// Backpressure: request is held by the master until the slave returns req_ack.
interface coin_collector_if;
  logic       req_valid;
  logic       req_mode;
  logic       req_func;
  logic [3:0] req_amount;
  logic       req_ack;
  logic       req_res;

  modport master (
    output req_valid, req_mode, req_func, req_amount,
    input  req_ack, req_res
  );

  modport slave (
    input  req_valid, req_mode, req_func, req_amount,
    output req_ack, req_res
  );
endinterface

// File: rtl/coin_collector.sv
// Coin collector: accumulates coin credit, issues one customer charge, refunds on refusal/timeout/cancel.
// Latency: 1 cycle from coin/commit/cancel/ack edge to registered outputs.
// Backpressure: request held until req_ack or timeout; coins arriving while busy are rejected.
module coin_collector #(
  parameter int MAX_PENDING    = 15,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             coin_valid_i,
  input  logic [1:0]       coin_value_i,
  input  logic             commit_i,
  input  logic             cancel_i,
  coin_collector_if.master req_if,
  output logic [3:0]       pending_o,
  output logic             busy_o,
  output logic             coin_reject_o,
  output logic             charge_ok_o,
  output logic             refund_valid_o,
  output logic [3:0]       refund_amount_o
);

  typedef enum logic {COLLECT = 1'b0, REQ = 1'b1} state_t;

  state_t     state_q;
  logic [3:0] pending_q;
  logic       req_valid_q;
  logic       req_func_q;
  logic [3:0] req_amount_q;
  logic [7:0] cnt_q;
  logic       coin_reject_q;
  logic       charge_ok_q;
  logic       refund_valid_q;
  logic [3:0] refund_amount_q;

  logic [4:0] coin_v_d;
  logic       coin_bad_d;
  logic [4:0] sum_d;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0] MAX_P    = 5'(MAX_PENDING);

  // Decode the coin code and form the 5-bit tentative sum so overflow cannot wrap.
  always_comb begin
    coin_bad_d = 1'b0;
    case (coin_value_i)
      2'b00:   coin_v_d = 5'd1;
      2'b01:   coin_v_d = 5'd2;
      2'b10:   coin_v_d = 5'd5;
      default: begin
        coin_v_d   = 5'd0;
        coin_bad_d = 1'b1;
      end
    endcase
    sum_d = {1'b0, pending_q} + coin_v_d;
  end

  // Main FSM: credit accumulation, request issue/hold, and one-cycle result pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= COLLECT;
      pending_q       <= 4'd0;
      req_valid_q     <= 1'b0;
      req_func_q      <= 1'b0;
      req_amount_q    <= 4'd0;
      cnt_q           <= 8'd0;
      coin_reject_q   <= 1'b0;
      charge_ok_q     <= 1'b0;
      refund_valid_q  <= 1'b0;
      refund_amount_q <= 4'd0;
    end else begin
      coin_reject_q   <= 1'b0;
      charge_ok_q     <= 1'b0;
      refund_valid_q  <= 1'b0;
      refund_amount_q <= 4'd0;
      case (state_q)
        COLLECT: begin
          if (cancel_i) begin
            // Cancel outranks everything; a simultaneous coin is bounced.
            if (pending_q != 4'd0) begin
              refund_valid_q  <= 1'b1;
              refund_amount_q <= pending_q;
              pending_q       <= 4'd0;
            end
            coin_reject_q <= coin_valid_i;
          end else if (commit_i && (pending_q != 4'd0)) begin
            state_q       <= REQ;
            req_valid_q   <= 1'b1;
            req_func_q    <= 1'b1;
            req_amount_q  <= pending_q;
            cnt_q         <= 8'd0;
            coin_reject_q <= coin_valid_i;
          end else if (coin_valid_i) begin
            if (coin_bad_d || (sum_d > MAX_P)) begin
              coin_reject_q <= 1'b1;
            end else begin
              pending_q <= sum_d[3:0];
            end
          end
        end
        REQ: begin
          coin_reject_q <= coin_valid_i;
          // Ack is checked first so it wins over a timeout on the same edge.
          if (req_if.req_ack || (cnt_q == CNT_LAST)) begin
            if (req_if.req_ack && req_if.req_res) begin
              charge_ok_q <= 1'b1;
            end else begin
              refund_valid_q  <= 1'b1;
              refund_amount_q <= pending_q;
            end
            state_q      <= COLLECT;
            pending_q    <= 4'd0;
            req_valid_q  <= 1'b0;
            req_func_q   <= 1'b0;
            req_amount_q <= 4'd0;
            cnt_q        <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign req_if.req_valid  = req_valid_q;
  assign req_if.req_mode   = 1'b0;
  assign req_if.req_func   = req_func_q;
  assign req_if.req_amount = req_amount_q;
  assign pending_o         = pending_q;
  assign busy_o            = (state_q == REQ);
  assign coin_reject_o     = coin_reject_q;
  assign charge_ok_o       = charge_ok_q;
  assign refund_valid_o    = refund_valid_q;
  assign refund_amount_o   = refund_amount_q;

endmodule
